// File: rtl/jtcps1_line_sched.sv
// Purpose: sequences the four layer engines (scroll1..3, objects) once per video line.
// Latency: go/abort/line_done are registered and appear one clk after the triggering event.
// Backpressure: none; a new line event while an engine is still running aborts it (overrun).
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   cen8, start       line event = cen8 && start
//   vrender, preVB    line number to render and its blanking flag (sampled at the line event)
//   layer_en          per-layer enable, sampled at the line event
//   done              per-engine completion pulse
//   ovr_clr           clears the overrun counter
//   go                one-hot engine start pulse
//   abort             kills the engine in progress on overrun
//   line_done         pulse when the whole line sequence has finished
//   busy              high while waiting on an engine
//   cur_line          line latched at the line event
//   ovr_cnt           saturating count of overrun lines
module jtcps1_line_sched #(
    parameter int SKIP_VB = 1,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen8,
    input  logic            start,
    input  logic [8:0]      vrender,
    input  logic            preVB,
    input  logic [3:0]      layer_en,
    input  logic [3:0]      done,
    input  logic            ovr_clr,
    output logic [3:0]      go,
    output logic            abort,
    output logic            line_done,
    output logic            busy,
    output logic [8:0]      cur_line,
    output logic [CNTW-1:0] ovr_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [3:0]        mask_q, mask_d;
    logic [3:0]        go_q, go_d;
    logic              abort_q, abort_d;
    logic              line_done_q, line_done_d;
    logic              busy_q, busy_d;
    logic [8:0]        cur_line_q, cur_line_d;
    logic [CNTW-1:0]   ovr_cnt_q, ovr_cnt_d;

    logic              le;
    logic              cur_done;
    logic              last_done;
    logic              ovr_inc;
    logic [2:0]        nxt;
    logic [2:0]        first;

    // Lowest set bit of m at index >= lo; result is {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= lo)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mask_d      = mask_q;
        go_d        = 4'b0000;
        abort_d     = 1'b0;
        line_done_d = 1'b0;
        cur_line_d  = cur_line_q;
        ovr_inc     = 1'b0;

        le        = cen8 & start;
        cur_done  = (state_q == WAIT) && done[k_q];
        nxt       = pick(mask_q, {1'b0, k_q} + 3'd1);
        first     = pick(layer_en, 3'd0);
        last_done = cur_done && !nxt[2];

        if (last_done) begin
            line_done_d = 1'b1;
            state_d     = IDLE;
        end else if (cur_done && !le) begin
            go_d = 4'b0001 << nxt[1:0];
            k_d  = nxt[1:0];
        end

        if (le) begin
            // Still waiting on an engine (including done of a non-last layer
            // landing on the event itself): the line ran out of time.
            if ((state_q == WAIT) && !last_done) begin
                abort_d = 1'b1;
                ovr_inc = 1'b1;
            end
            cur_line_d = vrender;
            mask_d     = layer_en;
            state_d    = IDLE;
            go_d       = 4'b0000;
            if ((SKIP_VB != 0) && preVB) begin
                // blanking line: nothing to render
            end else if (!first[2]) begin
                line_done_d = 1'b1;
            end else begin
                go_d    = 4'b0001 << first[1:0];
                k_d     = first[1:0];
                state_d = WAIT;
            end
        end

        busy_d = (state_d == WAIT);

        ovr_cnt_d = ovr_cnt_q;
        if (ovr_clr) begin
            ovr_cnt_d = '0;
        end else if (ovr_inc && (ovr_cnt_q != {CNTW{1'b1}})) begin
            ovr_cnt_d = ovr_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            mask_q      <= 4'b0000;
            go_q        <= 4'b0000;
            abort_q     <= 1'b0;
            line_done_q <= 1'b0;
            busy_q      <= 1'b0;
            cur_line_q  <= 9'd0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mask_q      <= mask_d;
            go_q        <= go_d;
            abort_q     <= abort_d;
            line_done_q <= line_done_d;
            busy_q      <= busy_d;
            cur_line_q  <= cur_line_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign go        = go_q;
    assign abort     = abort_q;
    assign line_done = line_done_q;
    assign busy      = busy_q;
    assign cur_line  = cur_line_q;
    assign ovr_cnt   = ovr_cnt_q;

endmodule

// File: doc/jtcps1_line_sched.md
JTCPS1_LINE_SCHED -- requirements
Module: jtcps1_line_sched

Interface
REQ-001 SHALL have parameter SKIP_VB, default 1, meaning no layer sequencing on lines flagged preVB.
REQ-002 SHALL have parameter CNTW, default 8, meaning overrun counter width.
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port cen8  in  1  pixel clock enable.
REQ-006 SHALL have port start  in  1  line-start flag from the timing generator; held high for one cen8 period.
REQ-007 SHALL have port vrender  in  9  line number to render.
REQ-008 SHALL have port preVB  in  1  blanking flag for the rendered line.
REQ-009 SHALL have port layer_en  in  4  enable per layer engine: bit0 scroll1, bit1 scroll2, bit2 scroll3, bit3 objects.
REQ-010 SHALL have port done  in  4  per-engine completion pulse.
REQ-011 SHALL have port ovr_clr  in  1  clears ovr_cnt.
REQ-012 SHALL have port go  out  4  per-engine one-clk start pulse.
REQ-013 SHALL have port abort  out  1  one-clk pulse that kills the engine in progress.
REQ-014 SHALL have port line_done  out  1  one-clk pulse when the line sequence completes.
REQ-015 SHALL have port busy  out  1  high while a sequence is in progress.
REQ-016 SHALL have port cur_line  out  9  line latched at the line event.
REQ-017 SHALL have port ovr_cnt  out  CNTW  saturating count of overrun lines.

Function
REQ-018 SHALL define the line event (LE) as cen8 && start in one clk cycle; no other condition starts a sequence.
REQ-019 SHALL, at LE, latch vrender into cur_line and layer_en into an internal mask; layer_en changes mid-line SHALL have no effect.
REQ-020 SHALL use two states, IDLE and WAIT(k), k = 0..3; busy SHALL be 1 exactly in WAIT.
REQ-021 SHALL, at LE with SKIP_VB=1 and preVB=1, issue no go, stay IDLE, and pulse neither line_done nor abort.
REQ-022 SHALL, at LE otherwise, pulse go[k] in cycle LE+1 for the lowest enabled k and enter WAIT(k).
REQ-023 SHALL, at LE with mask=0, pulse line_done in cycle LE+1 and stay IDLE.
REQ-024 SHALL, in WAIT(k), respond to done[k] only; done[j] with j!=k SHALL be ignored.
REQ-025 SHALL, on done[k] in cycle M, pulse go[j] in M+1 for the next enabled j>k and enter WAIT(j); if no such j, it SHALL pulse line_done in M+1 and enter IDLE.
REQ-026 SHALL keep go at most one-hot; never more than one engine active.
REQ-027 SHALL treat LE while in WAIT(k) without done[k] as overrun: abort pulses in LE+1; ovr_cnt increments, saturating at all-ones; the new line then starts per REQ-021..023, with its first go in LE+1 in the same cycle as abort.
REQ-028 SHALL treat LE coincident with done[k] of the last enabled layer as normal completion: line_done pulses and the new line starts in LE+1, with no abort and no overrun.
REQ-029 SHALL treat LE coincident with done[k] of a non-last layer as overrun per REQ-027.
REQ-030 SHALL give ovr_clr priority over an increment in the same cycle; the result SHALL be 0.
REQ-031 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-032 SHALL, while rst_n=0 at posedge clk, force IDLE, go=0, abort=0, line_done=0, busy=0, cur_line=0, ovr_cnt=0, mask=0.
REQ-033 SHALL, on reset asserted mid-sequence, issue no abort pulse; a pending done SHALL be ignored after reset is released.
REQ-034 SHALL ignore LE in the cycle rst_n=0.

Verification
REQ-035 SHALL cover: layer_en=4'b1111, preVB=0, LE with vrender=9'd20, done returned 10 clk after each go -> go sequence 1,2,4,8; go[0] at LE+1; line_done 1 clk after done[3]; cur_line=20.
REQ-036 SHALL cover: layer_en=4'b1010 -> only go[1] then go[3]; done[0] injected in WAIT(1) has no effect.
REQ-037 SHALL cover: preVB=1, SKIP_VB=1, LE -> no go, busy=0, no line_done; with SKIP_VB=0 -> normal sequence.
REQ-038 SHALL cover: done[2] withheld, next LE -> abort and go[0] both in LE+1; ovr_cnt 0->1; 300 overruns with CNTW=8 -> ovr_cnt=255.
REQ-039 SHALL cover: done[3] coincident with LE -> line_done=1, abort=0, ovr_cnt unchanged, go[0] in LE+1.
REQ-040 SHALL cover: rst_n=0 for 1 clk during WAIT(1) -> all outputs 0 next cycle; later done[1] ignored; next LE starts cleanly.
